// File: rtl/packed_mul_unit_pkg.sv
// Shared definitions for the packed multiply unit.
// Holds the ALU op codes that select the packed multiplies, the FSM state
// encoding, and the index of the last lane for each lane size.
package packed_mul_unit_pkg;

  localparam logic [5:0] ALU_SMUL16 = 6'b100010;
  localparam logic [5:0] ALU_UMUL16 = 6'b100011;
  localparam logic [5:0] ALU_SMUL8  = 6'b100100;
  localparam logic [5:0] ALU_UMUL8  = 6'b100101;

  // Index of the final lane: two 16-bit lanes or four 8-bit lanes per word.
  localparam logic [1:0] LAST16 = 2'd1;
  localparam logic [1:0] LAST8  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the four op codes this unit executes.
  function automatic logic is_mul_op(input logic [5:0] code);
    return (code == ALU_SMUL16) || (code == ALU_UMUL16) ||
           (code == ALU_SMUL8)  || (code == ALU_UMUL8);
  endfunction

endpackage

// File: rtl/packed_mul_unit_lane_mul17.sv
// lane_mul17: combinational 17x17 signed multiplier.
// Kept on its own so it can be retimed or swapped for a DSP macro without
// touching the control logic.
//   a, b : 17-bit signed operands (already sign/zero extended by the caller)
//   p    : full 34-bit signed product
module lane_mul17 (
  input  logic signed [16:0] a,
  input  logic signed [16:0] b,
  output logic signed [33:0] p
);

  assign p = a * b;

endmodule

// File: rtl/packed_mul_unit.sv
// packed_mul_unit: iterative execute-stage multiplier for the packed
// smul16/umul16/smul8/umul8 ops. One lane product per cycle is computed on
// a single shared 17x17 multiplier and assembled into a 64-bit result.
//
// Handshake: an op is taken when the unit is IDLE, start_e=1, alu_control_e
// is a multiply code and flush_e=0. stall_o holds F/D/E from that accept
// cycle through the last RUN cycle; in DONE stall_o drops and valid_o pulses
// for exactly one cycle so writeback captures result_hi_o/result_lo_o while
// the pipeline advances. flush_e abandons an op in flight and suppresses
// valid_o in the same cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_e           valid instruction in EX
//   alu_control_e     decoded ALU op
//   src_a_e, src_b_e  forwarded rs1/rs2 values
//   flush_e           EX flush
//   stall_o           stall request for F/D/E (combinational)
//   busy_o            unit is not IDLE (decoded from the state register)
//   valid_o           one-cycle result-valid pulse
//   result_lo_o/hi_o  low/high words of the 64-bit result
module packed_mul_unit
  import packed_mul_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_e,
  input  logic [5:0]        alu_control_e,
  input  logic [DATA_W-1:0] src_a_e,
  input  logic [DATA_W-1:0] src_b_e,
  input  logic              flush_e,
  output logic              stall_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_lo_o,
  output logic [DATA_W-1:0] result_hi_o
);

  state_t              state;
  logic [1:0]          cnt;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                uns_q;   // 1 = unsigned lanes
  logic                byte_q;  // 1 = 8-bit lanes
  logic [2*DATA_W-1:0] res_q;

  logic               accept;
  logic [1:0]         last_lane;
  logic [7:0]         lane_a8, lane_b8;
  logic [15:0]        lane_a16, lane_b16;
  logic signed [16:0] op_a, op_b;
  logic signed [33:0] prod;
  logic               unused_prod_hi;

  assign accept    = (state == IDLE) && start_e && is_mul_op(alu_control_e) && !flush_e;
  assign last_lane = byte_q ? LAST8 : LAST16;

  // Pick lane cnt from the latched operands and widen it to 17 bits so one
  // signed multiplier serves both signed and unsigned lanes.
  always_comb begin
    lane_a8  = a_q[{cnt, 3'b000} +: 8];
    lane_b8  = b_q[{cnt, 3'b000} +: 8];
    lane_a16 = a_q[{cnt[0], 4'b0000} +: 16];
    lane_b16 = b_q[{cnt[0], 4'b0000} +: 16];
    op_a     = '0;
    op_b     = '0;
    if (byte_q) begin
      op_a = {{9{~uns_q & lane_a8[7]}}, lane_a8};
      op_b = {{9{~uns_q & lane_b8[7]}}, lane_b8};
    end else begin
      op_a = {~uns_q & lane_a16[15], lane_a16};
      op_b = {~uns_q & lane_b16[15], lane_b16};
    end
  end

  lane_mul17 u_lane_mul17 (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // The top two product bits never reach a result slot.
  assign unused_prod_hi = ^prod[33:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      uns_q  <= 1'b0;
      byte_q <= 1'b0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= src_a_e;
            b_q    <= src_b_e;
            uns_q  <= alu_control_e[0];
            byte_q <= alu_control_e[2];
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_e) begin
            state <= IDLE;
          end else begin
            if (byte_q) res_q[{cnt, 4'b0000} +: 16] <= prod[15:0];
            else        res_q[{cnt[0], 5'b00000} +: 32] <= prod[31:0];
            cnt <= cnt + 2'd1;
            if (cnt == last_lane) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign valid_o     = (state == DONE) && !flush_e;
  assign stall_o     = !rst && (accept || ((state == RUN) && !flush_e));
  assign result_lo_o = res_q[DATA_W-1:0];
  assign result_hi_o = res_q[2*DATA_W-1:DATA_W];

endmodule
